ripple_cnt_ctrl: RTL
====================

# ripple_cnt_ctrl

Synchronous sequencer for the asynchronous ripple counter (`counterb`). It clears the counter and opens its count gate for a programmed window of `clk` cycles. It then waits for the ripple chain to settle, captures the count into a synchronous result register, and delivers the result over a valid/ready handshake. It sits between the software-visible measurement logic and the raw ripple counter instance.

## Interface
Parameters:
- N, 32: ripple counter width and result width.
- W, 16: width of the window length input.
- CLR_CYCLES, 2: cycles `cnt_clr` is held high after `start`; must be ≥1.
- SETTLE_CYCLES, 4: cycles waited after the gate closes, before capture; must be ≥1.

Ports:
- clk  in  1  system clock.
- arst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a measurement; sampled only in IDLE.
- window_len  in  W  gate-open length in cycles; latched when `start` is accepted.
- busy  out  1  high in every state except IDLE.
- cnt_clr  out  1  drives the counter's `arst`.
- cnt_gate  out  1  count enable for the counter's input; glitch-free.
- cnt_value  in  N  raw ripple counter output; asynchronous to `clk`.
- result  out  N  captured count.
- result_valid  out  1  `result` is available.
- result_ready  in  1  consumer accepts `result`.

## Operation
- States: IDLE, CLEAR, WINDOW, SETTLE, CAPTURE, HOLD.
- IDLE:
  - `cnt_clr`=1, `cnt_gate`=0.
  - On `start`=1: latch `window_len` into `win_q` and go to CLEAR.
- CLEAR:
  - `cnt_clr`=1 for exactly CLR_CYCLES cycles.
  - Then go to WINDOW. If `win_q`==0, go directly to SETTLE instead (gate never opens).
- WINDOW: `cnt_clr`=0 and `cnt_gate`=1 for exactly `win_q` cycles, then go to SETTLE.
- SETTLE: `cnt_gate`=0 for SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: one cycle; `result` <= `cnt_value`, then go to HOLD.
- HOLD:
  - `result_valid`=1.
  - A transfer occurs on a cycle with `result_valid`&&`result_ready`; next state is IDLE.
  - `result` stays stable until the transfer.
- `start` outside IDLE is ignored; it is neither queued nor an error.
- `window_len` changes after acceptance have no effect on the current run.
- `cnt_value` may be sampled only in CAPTURE. No other logic reads it.
- Counter wrap-around within the window is not detected. The caller keeps `win_q` × event rate below 2^N.
- All timers are down-counters loaded on state entry. Each state lasts exactly its programmed count.

## Timing
- Reset values:
  - state=IDLE
  - `cnt_clr`=1, `cnt_gate`=0
  - `busy`=0
  - `result`=0, `result_valid`=0
- All outputs are registered and change only on the rising edge of `clk`. `cnt_gate` and `cnt_clr` are free of glitches.
- `start` accepted at edge 0 → `busy`=1 and `cnt_clr`=1 from edge 0.
- `cnt_gate` high from edge CLR_CYCLES to edge CLR_CYCLES+`win_q`.
- `result_valid` rises at edge CLR_CYCLES+`win_q`+SETTLE_CYCLES+1.
- Consequence: with `win_q`=0, `result_valid` rises at edge CLR_CYCLES+SETTLE_CYCLES+1.
- A transfer at edge t → `result_valid`=0 and `busy`=0 after edge t. A new `start` is accepted at edge t+1 at the earliest.
- `arst` mid-operation: immediate return to reset values, including a closed gate and an asserted clear. Any pending result is lost.

## Configuration
- `RIPPLE_AUTO_RESTART_EN` defined: a HOLD transfer goes directly to CLEAR (`busy` stays 1) and reuses `win_q`. This gives back-to-back measurements, where `start` is needed only for the first run.
- Undefined: a HOLD transfer returns to IDLE, and every run requires `start`.

## Structure
- Shared package `counters_pkg` holds:
  - the state enumeration type `rcc_state_t`;
  - localparams for the timer width, `$clog2` of max(CLR_CYCLES, SETTLE_CYCLES, 2^W−1)+1.
- One sub-module, `ctrl_down_timer`, is natural: a loadable down-counter with a `done` flag. A single instance is reloaded on entry to CLEAR, WINDOW and SETTLE.
- The FSM and the capture register live in the top module.

## Test plan
- Reset mid-WINDOW:
  - Setup: assert `arst` while `cnt_gate`=1.
  - Required: `cnt_gate`=0, `cnt_clr`=1, `busy`=0 immediately; after release, `start` is accepted normally.
- Nominal run:
  - Setup: N=8, `window_len`=10, counter model increments once per gated cycle.
  - Required: `cnt_gate` high for exactly 10 cycles; `result`=10 and `result_valid`=1 at edge 2+10+4+1=17 after `start`.
- Zero window:
  - Setup: `window_len`=0.
  - Required: `cnt_gate` never rises; `result`=0 and valid at edge 7.
- Backpressure:
  - Setup: `result_ready`=0 for 20 cycles, then 1.
  - Required: `result` and `result_valid` hold for the full 20 cycles; transfer on the first ready cycle; `busy` falls on the next edge.
- Ignored start:
  - Setup: `start` pulses in WINDOW and SETTLE, and `window_len` changes from 10 to 3.
  - Required: a single result of 10; no second run.
- Auto-restart (`RIPPLE_AUTO_RESTART_EN` defined):
  - Setup: `window_len`=5 with `result_ready`=1 held.
  - Required: results arrive every 2+5+4+1+1=13 cycles, with `busy` held continuously at 1.

Source files
------------

// File: rtl/counters_pkg.sv
// Shared definitions for the ripple counter sequencer: state type and timer sizing.
package counters_pkg;

  typedef enum logic [2:0] {
    RCC_IDLE,
    RCC_CLEAR,
    RCC_WINDOW,
    RCC_SETTLE,
    RCC_CAPTURE,
    RCC_HOLD
  } rcc_state_t;

  localparam int RCC_CLR_CYCLES_DEF    = 2;
  localparam int RCC_SETTLE_CYCLES_DEF = 4;
  localparam int RCC_W_DEF             = 16;

  // Timer must hold the largest of the three programmed durations.
  function automatic int rcc_timer_w(input int clr, input int settle, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    if (longint'(clr) > m) m = longint'(clr);
    if (longint'(settle) > m) m = longint'(settle);
    return $clog2(m + 1);
  endfunction

  localparam int RCC_TIMER_W_DEF =
    rcc_timer_w(RCC_CLR_CYCLES_DEF, RCC_SETTLE_CYCLES_DEF, RCC_W_DEF);

endpackage

// File: rtl/ctrl_down_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// A load of value v makes done_o rise v cycles after the loading edge.
module ctrl_down_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ripple_cnt_ctrl.sv
// Sequencer for the asynchronous ripple counter: clear, gated window, settle, capture, handshake.
// Define RIPPLE_AUTO_RESTART_EN to restart a run with the same window right after each transfer.
module ripple_cnt_ctrl
  import counters_pkg::*;
#(
  parameter int N             = 32,
  parameter int W             = 16,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         start,
  input  logic [W-1:0] window_len,
  output logic         busy,
  output logic         cnt_clr,
  output logic         cnt_gate,
  input  logic [N-1:0] cnt_value,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ready
);

  localparam int TW = rcc_timer_w(CLR_CYCLES, SETTLE_CYCLES, W);

  rcc_state_t    state_q, state_d;
  logic [W-1:0]  win_q, win_d;
  logic [N-1:0]  result_q, result_d;
  logic          busy_q, clr_q, gate_q, valid_q;
  logic          busy_d, clr_d, gate_d, valid_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  ctrl_down_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .arst       (arst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Timer is loaded with (duration - 1) so a state lasts exactly its duration.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      RCC_IDLE: begin
        if (start) begin
          win_d    = window_len;
          state_d  = RCC_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = TW'(CLR_CYCLES - 1);
        end
      end
      RCC_CLEAR: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (win_q == '0) begin
            state_d = RCC_SETTLE;
            tmr_val = TW'(SETTLE_CYCLES - 1);
          end else begin
            state_d = RCC_WINDOW;
            tmr_val = TW'(win_q) - TW'(1);
          end
        end
      end
      RCC_WINDOW: begin
        if (tmr_done) begin
          state_d  = RCC_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETTLE_CYCLES - 1);
        end
      end
      RCC_SETTLE: begin
        if (tmr_done) state_d = RCC_CAPTURE;
      end
      RCC_CAPTURE: begin
        state_d = RCC_HOLD;
      end
      RCC_HOLD: begin
        if (result_ready) begin
`ifdef RIPPLE_AUTO_RESTART_EN
          state_d  = RCC_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = TW'(CLR_CYCLES - 1);
`else
          state_d  = RCC_IDLE;
`endif
        end
      end
      default: state_d = RCC_IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so gate/clear never glitch.
  always_comb begin
    busy_d   = (state_d != RCC_IDLE);
    clr_d    = (state_d == RCC_IDLE) || (state_d == RCC_CLEAR);
    gate_d   = (state_d == RCC_WINDOW);
    valid_d  = (state_d == RCC_HOLD);
    result_d = (state_q == RCC_CAPTURE) ? cnt_value : result_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= RCC_IDLE;
      win_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b1;
      gate_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
      gate_q   <= gate_d;
      valid_q  <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign cnt_clr      = clr_q;
  assign cnt_gate     = gate_q;
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule
